// File: rtl/ast_rr_arbiter.sv
// rtl/ast_rr_arbiter.sv - packet-level round-robin Avalon-ST arbiter feeding one FIFO sink.
// Define AST_ARB_STATS_EN to add per-source completed-packet counters on pkt_cnt_o.
module ast_rr_arbiter #(
    parameter int NUM_SRC             = 4,
    parameter int DATABITS_PER_SYMBOL = 8,
    parameter int SYMBOLS_PER_BEAT    = 4,
    parameter int WIDTH               = SYMBOLS_PER_BEAT * DATABITS_PER_SYMBOL,
    parameter int CH_W                = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    parameter int CNT_W               = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_SRC*WIDTH-1:0] snk_data_i,
    input  logic [NUM_SRC-1:0]       snk_valid_i,
    input  logic [NUM_SRC-1:0]       snk_sop_i,
    input  logic [NUM_SRC-1:0]       snk_eop_i,
    output logic [NUM_SRC-1:0]       snk_ready_o,
    output logic [WIDTH-1:0]         src_data_o,
    output logic                     src_valid_o,
    output logic                     src_sop_o,
    output logic                     src_eop_o,
    output logic [CH_W-1:0]          src_channel_o,
    input  logic                     src_ready_i,
    output logic                     busy_o
`ifdef AST_ARB_STATS_EN
    ,
    output logic [NUM_SRC*CNT_W-1:0] pkt_cnt_o
`endif
);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   grant_q, grant_d;
    logic [CH_W-1:0]   last_grant_q, last_grant_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              sop_q, sop_d;
    logic              eop_q, eop_d;
    logic              valid_q, valid_d;
    logic [CH_W-1:0]   chan_q, chan_d;
    logic              out_free;
    logic              accept;
    logic [CH_W:0]     pick;

    // Returns {found, index} of the first request strictly after 'last', wrapping.
    function automatic logic [CH_W:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                              input logic [CH_W-1:0]    last);
        logic [CH_W:0]   res;
        logic [CH_W-1:0] cur;
        res = '0;
        cur = last;
        for (int i = 0; i < NUM_SRC; i++) begin
            cur = (cur == CH_W'(NUM_SRC - 1)) ? '0 : cur + 1'b1;
            if (!res[CH_W] && req[cur]) res = {1'b1, cur};
        end
        return res;
    endfunction

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        data_d       = data_q;
        sop_d        = sop_q;
        eop_d        = eop_q;
        valid_d      = valid_q;
        chan_d       = chan_q;
        snk_ready_o  = '0;
        accept       = 1'b0;
        out_free     = !valid_q || src_ready_i;
        pick         = rr_pick(snk_valid_i & snk_sop_i, last_grant_q);

        case (state_q)
            IDLE: begin
                if (pick[CH_W]) begin
                    state_d = LOCK;
                    grant_d = pick[CH_W-1:0];
                end
            end
            LOCK: begin
                snk_ready_o[grant_q] = out_free;
                accept = snk_valid_i[grant_q] && out_free;
                if (accept && snk_eop_i[grant_q]) begin
                    state_d      = IDLE;
                    last_grant_d = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase

        // The output register drains in either state; it only loads on an accepted beat.
        if (accept) begin
            data_d  = snk_data_i[int'(grant_q)*WIDTH +: WIDTH];
            sop_d   = snk_sop_i[grant_q];
            eop_d   = snk_eop_i[grant_q];
            chan_d  = grant_q;
            valid_d = 1'b1;
        end else if (out_free) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= CH_W'(NUM_SRC - 1);
            data_q       <= '0;
            sop_q        <= 1'b0;
            eop_q        <= 1'b0;
            valid_q      <= 1'b0;
            chan_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            data_q       <= data_d;
            sop_q        <= sop_d;
            eop_q        <= eop_d;
            valid_q      <= valid_d;
            chan_q       <= chan_d;
        end
    end

    assign src_data_o    = data_q;
    assign src_valid_o   = valid_q;
    assign src_sop_o     = sop_q;
    assign src_eop_o     = eop_q;
    assign src_channel_o = chan_q;
    assign busy_o        = (state_q == LOCK);

`ifdef AST_ARB_STATS_EN
    logic [CNT_W-1:0] cnt_q [NUM_SRC];
    logic [CNT_W-1:0] cnt_d [NUM_SRC];

    always_comb begin
        cnt_d = cnt_q;
        if (accept && snk_eop_i[grant_q]) cnt_d[grant_q] = cnt_q[grant_q] + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int s = 0; s < NUM_SRC; s++) cnt_q[s] <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_cnt
        assign pkt_cnt_o[s*CNT_W +: CNT_W] = cnt_q[s];
    end
`endif

endmodule
